// File: rtl/preamble_pkg.sv
// Shared definitions for the preamble inserter and the receiver-side sync blocks:
// settings addresses, sample layout and the framer state encoding.
package preamble_pkg;

    localparam int SAMPLE_W = 32;

    localparam logic [7:0] SR_PRE_ADDR_DEF = 8'd0;
    localparam logic [7:0] SR_PRE_DATA_DEF = 8'd1;
    localparam logic [7:0] SR_NUM_REPS_DEF = 8'd2;
    localparam logic [7:0] SR_ENABLE_DEF   = 8'd3;

    localparam logic [3:0] NUM_REPS_RST = 4'd2;

    // I occupies the upper half of a sample word, Q the lower half.
    localparam int IQ_I_MSB = 31;
    localparam int IQ_I_LSB = 16;
    localparam int IQ_Q_MSB = 15;
    localparam int IQ_Q_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2
    } pre_state_e;

endpackage

// File: rtl/preamble_ram.sv
// Preamble sample store: one write port, one synchronous read port with a
// single cycle of read latency. Contents are deliberately not reset.
module preamble_ram
    import preamble_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/preamble_inserter.sv
// Prepends NUM_REPS copies of a programmable training window to each packet,
// then passes the payload through a single registered output stage.
module preamble_inserter
    import preamble_pkg::*;
#(
    parameter int         WINDOW_LEN  = 64,
    parameter logic [7:0] SR_PRE_ADDR = SR_PRE_ADDR_DEF,
    parameter logic [7:0] SR_PRE_DATA = SR_PRE_DATA_DEF,
    parameter logic [7:0] SR_NUM_REPS = SR_NUM_REPS_DEF,
    parameter logic [7:0] SR_ENABLE   = SR_ENABLE_DEF
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        sof,
    output logic        busy
);

    localparam int AW = $clog2(WINDOW_LEN);

    pre_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d, wr_ptr_q, wr_ptr_d, rd_addr;
    logic [3:0]    rep_q, rep_d, reps_lat_q, reps_lat_d, num_reps_q, num_reps_d;
    logic          enable_q, enable_d;
    logic [31:0]   o_tdata_q, o_tdata_d;
    logic          o_tvalid_q, o_tvalid_d, o_tlast_q, o_tlast_d, first_q, first_d;
    logic [31:0]   ram_rdata;
    logic          out_ready, in_fire, pre_load, last_pre, ram_we;

    assign out_ready = !o_tvalid_q || o_tready;
    assign i_tready  = (state_q == ST_PAYLOAD) && out_ready;
    assign in_fire   = i_tvalid && i_tready;
    assign pre_load  = (state_q == ST_PREAMBLE) && out_ready;
    assign last_pre  = pre_load && (idx_q == {AW{1'b1}}) && (rep_q == reps_lat_q - 4'd1);
    assign ram_we    = set_stb && (set_addr == SR_PRE_DATA);

    preamble_ram #(.DEPTH(WINDOW_LEN), .AW(AW)) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (set_data),
        .rd_addr (rd_addr),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_tvalid) begin
                    state_d = (enable_q && (num_reps_q != 4'd0)) ? ST_PREAMBLE : ST_PAYLOAD;
                end
            end
            ST_PREAMBLE: if (last_pre) state_d = ST_PAYLOAD;
            ST_PAYLOAD:  if (in_fire && i_tlast) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    // Settings registers are independent of the framer and survive clear.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        num_reps_d = num_reps_q;
        enable_d   = enable_q;
        if (set_stb) begin
            if (set_addr == SR_PRE_ADDR) wr_ptr_d = set_data[AW-1:0];
            if (set_addr == SR_PRE_DATA) wr_ptr_d = wr_ptr_q + 1'b1;
            if (set_addr == SR_NUM_REPS) num_reps_d = set_data[3:0];
            if (set_addr == SR_ENABLE)   enable_d = set_data[0];
        end
    end

    // rd_data always holds RAM[idx_q]: the address runs one ahead whenever a
    // preamble beat is loaded, so consecutive beats need no wait for the read.
    always_comb begin
        idx_d      = idx_q;
        rep_d      = rep_q;
        reps_lat_d = reps_lat_q;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        o_tvalid_d = o_tvalid_q;
        first_d    = first_q;
        rd_addr    = idx_q;
        if (o_tvalid_q && o_tready) begin
            o_tvalid_d = 1'b0;
            first_d    = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                rep_d = 4'd0;
                if (i_tvalid) reps_lat_d = num_reps_q;
            end
            ST_PREAMBLE: begin
                if (pre_load) begin
                    o_tdata_d  = ram_rdata;
                    o_tlast_d  = 1'b0;
                    o_tvalid_d = 1'b1;
                    first_d    = (idx_q == '0) && (rep_q == 4'd0);
                    idx_d      = idx_q + 1'b1;
                    rd_addr    = idx_q + 1'b1;
                    if (idx_q == {AW{1'b1}}) begin
                        rep_d = last_pre ? 4'd0 : rep_q + 4'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_fire) begin
                    o_tdata_d  = i_tdata;
                    o_tlast_d  = i_tlast;
                    o_tvalid_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (clear) begin
            o_tvalid_d = 1'b0;
            first_d    = 1'b0;
            idx_d      = '0;
            rep_d      = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            idx_q      <= '0;
            rep_q      <= 4'd0;
            reps_lat_q <= 4'd0;
            wr_ptr_q   <= '0;
            num_reps_q <= NUM_REPS_RST;
            enable_q   <= 1'b0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_tvalid_q <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            rep_q      <= rep_d;
            reps_lat_q <= reps_lat_d;
            wr_ptr_q   <= wr_ptr_d;
            num_reps_q <= num_reps_d;
            enable_q   <= enable_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
            o_tvalid_q <= o_tvalid_d;
            first_q    <= first_d;
        end
    end

    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_tvalid = o_tvalid_q;
    assign sof      = o_tvalid_q && o_tready && first_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_preamble_inserter.sv
// Bench for preamble_inserter: table of frame scenarios checked against a
// scoreboard, plus hand-written mid-frame settings, clear and reset sequences.
module tb_preamble_inserter;

    localparam logic [7:0] A_PTR  = 8'd0;
    localparam logic [7:0] A_DATA = 8'd1;
    localparam logic [7:0] A_REPS = 8'd2;
    localparam logic [7:0] A_EN   = 8'd3;
    localparam int LIMIT = 3000;

    logic        clk, aresetn, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data, i_tdata, o_tdata;
    logic        i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready, sof, busy;

    preamble_inserter #(.WINDOW_LEN(64)) dut (
        .clk(clk), .aresetn(aresetn), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .sof(sof), .busy(busy)
    );

    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct { logic en; logic [3:0] reps; int n; logic rnd; int exp_beats; int exp_sof; } vec_t;

    beat_t       sb[$];
    vec_t        vecs[6];
    logic [31:0] model_ram [64];
    logic [5:0]  model_ptr;
    logic [3:0]  model_reps;
    logic        model_en;
    int checks = 0, failures = 0;
    int cyc = 0, frame_beats = 0, first_cyc = 0, last_cyc = 0, sof_cnt = 0, in_acc_cyc = 0;
    logic rnd_mode = 1'b0, abort = 1'b0;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        o_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a beat counts as accepted when valid&&ready are seen mid-cycle.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (aresetn) begin
            if (prev_stall) begin
                check("hold_valid", o_tvalid, 1);
                check("hold_data", o_tdata, prev_data);
                check("hold_last", o_tlast, prev_last);
            end
            if (sof) sof_cnt++;
            if (o_tvalid && o_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %0h expected none", o_tdata);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", o_tdata, e.data);
                    check("beat_last", o_tlast, e.last);
                end
                if (frame_beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                frame_beats++;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
            prev_last  = o_tlast;
        end
    end

    task automatic write_set(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        case (a)
            A_PTR:  model_ptr = d[5:0];
            A_DATA: begin model_ram[model_ptr] = d; model_ptr = model_ptr + 6'd1; end
            A_REPS: model_reps = d[3:0];
            A_EN:   model_en = d[0];
            default: ;
        endcase
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic push_frame(input int n, input logic [31:0] base);
        if (model_en && model_reps != 4'd0) begin
            for (int r = 0; r < int'(model_reps); r++)
                for (int k = 0; k < 64; k++) sb.push_back('{model_ram[k], 1'b0});
        end
        for (int k = 0; k < n; k++) sb.push_back('{base + k, (k == n - 1)});
    endtask

    task automatic send_packet(input int n, input logic [31:0] base);
        for (int k = 0; k < n && !abort; k++) begin
            int t = 0;
            i_tvalid = 1'b1; i_tdata = base + k; i_tlast = (k == n - 1);
            @(negedge clk);
            while (!i_tready && !abort && t < LIMIT) begin
                @(negedge clk);
                t++;
            end
            if (t >= LIMIT) begin
                check("input_timeout", t, 0);
                break;
            end
            if (abort) break;
            if (k == 0) in_acc_cyc = cyc + 1;
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || o_tvalid) && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", (t < LIMIT), 1);
        check("idle_after", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o_tvalid"}, o_tvalid, 0);
        check({tag, "_o_tlast"}, o_tlast, 0);
        check({tag, "_o_tdata"}, o_tdata, 0);
        check({tag, "_sof"}, sof, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_i_tready"}, i_tready, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd2, 10, 1'b0, 138, 1};
        vecs[1] = '{1'b0, 4'd2, 5,  1'b0, 5,   0};
        vecs[2] = '{1'b1, 4'd1, 7,  1'b1, 71,  1};
        vecs[3] = '{1'b1, 4'd0, 3,  1'b0, 3,   0};
        vecs[4] = '{1'b1, 4'd1, 1,  1'b0, 65,  1};
        vecs[5] = '{1'b1, 4'd2, 6,  1'b1, 134, 1};

        clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        model_ptr = '0; model_reps = 4'd2; model_en = 1'b0;
        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        #1 check_reset_outputs("reset");
        #20;
        @(negedge clk) aresetn = 1'b1;
        @(posedge clk); #1;

        write_set(A_PTR, 32'd0);
        for (int k = 0; k < 64; k++) write_set(A_DATA, k);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] base;
            base = 32'h1000 * (i + 1);
            rnd_mode = vecs[i].rnd;
            write_set(A_REPS, {28'd0, vecs[i].reps});
            write_set(A_EN, {31'd0, vecs[i].en});
            sof_cnt = 0; frame_beats = 0;
            push_frame(vecs[i].n, base);
            send_packet(vecs[i].n, base);
            drain();
            $display("vector %0d: en=%0d reps=%0d n=%0d beats=%0d sof=%0d", i, vecs[i].en,
                     vecs[i].reps, vecs[i].n, frame_beats, sof_cnt);
            check("frame_beats", frame_beats, vecs[i].exp_beats);
            check("sof_count", sof_cnt, vecs[i].exp_sof);
            if (!vecs[i].rnd) check("gap_free_span", last_cyc - first_cyc, frame_beats - 1);
            if (!(vecs[i].en && vecs[i].reps != 4'd0)) check("latency", first_cyc - in_acc_cyc + 1, 1);
        end
        rnd_mode = 1'b0;

        // Repetition count rewritten during payload applies only to the next frame.
        write_set(A_REPS, 32'd1);
        frame_beats = 0;
        push_frame(20, 32'h2000);
        fork
            send_packet(20, 32'h2000);
            begin
                int t = 0;
                while (frame_beats < 67 && t < LIMIT) begin @(negedge clk); t++; end
                @(posedge clk); #1;
                write_set(A_REPS, 32'd3);
            end
        join
        drain();
        $display("midframe reps frame1: beats=%0d", frame_beats);
        check("midframe_f1_beats", frame_beats, 84);
        frame_beats = 0;
        push_frame(4, 32'h2100);
        send_packet(4, 32'h2100);
        drain();
        $display("midframe reps frame2: beats=%0d", frame_beats);
        check("midframe_f2_beats", frame_beats, 196);

        // Clear in the middle of the preamble, held packet restarts a fresh preamble.
        write_set(A_REPS, 32'd2);
        frame_beats = 0;
        push_frame(4, 32'h3000);
        fork
            send_packet(4, 32'h3000);
            begin
                int t = 0;
                while (frame_beats < 30 && t < LIMIT) begin @(negedge clk); t++; end
                @(posedge clk); #1 clear = 1'b1;
                @(posedge clk); #1 clear = 1'b0;
                check("clear_o_tvalid", o_tvalid, 0);
                check("clear_busy", busy, 0);
                sb.delete();
                frame_beats = 0;
                push_frame(4, 32'h3000);
            end
        join
        drain();
        $display("after clear: beats=%0d", frame_beats);
        check("clear_fresh_beats", frame_beats, 132);
        check("clear_gap_free", last_cyc - first_cyc, frame_beats - 1);

        // Asynchronous reset pulse mid-payload.
        write_set(A_REPS, 32'd3);
        frame_beats = 0;
        push_frame(40, 32'h4000);
        fork
            send_packet(40, 32'h4000);
            begin
                int t = 0;
                while (frame_beats < 197 && t < LIMIT) begin @(negedge clk); t++; end
                #2;
                abort = 1'b1; i_tvalid = 1'b0;
                aresetn = 1'b0;
                #1 check_reset_outputs("midreset");
                aresetn = 1'b1;
                sb.delete();
                model_reps = 4'd2; model_en = 1'b0;
            end
        join
        abort = 1'b0;
        @(posedge clk); #1;
        write_set(A_EN, 32'd1);
        frame_beats = 0; sof_cnt = 0;
        push_frame(3, 32'h5000);
        send_packet(3, 32'h5000);
        drain();
        $display("after reset: beats=%0d sof=%0d", frame_beats, sof_cnt);
        check("reset_reps_default", frame_beats, 131);
        check("reset_sof", sof_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
